// File: rtl/image_frame_parser_if.sv
// image_frame_parser_if: byte stream in from the UART receiver, framed payload strobes out to storage.
// master: upstream side (drives rx_byte/rx_valid, observes the parser outputs)
// slave:  parser side (consumes rx_byte/rx_valid, drives data_out/data_valid/image_start/
//         image_end/frame_error/char_count)
interface image_frame_parser_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        image_start;
    logic        image_end;
    logic        frame_error;
    logic [13:0] char_count;
    modport master (
        output rx_byte, rx_valid,
        input  data_out, data_valid, image_start, image_end, frame_error, char_count
    );
    modport slave (
        input  rx_byte, rx_valid,
        output data_out, data_valid, image_start, image_end, frame_error, char_count
    );
endinterface

// File: rtl/image_frame_parser.sv
// image_frame_parser: finds the "IMG:" header, forwards base64 payload bytes, closes the frame on LF.
// Ports: clk; reset (synchronous, active-high); bus (slave) carries rx_byte/rx_valid in and
// data_out/data_valid/image_start/image_end/frame_error/char_count out.
module image_frame_parser #(
    parameter int EXPECTED_CHARS = 10240,
    parameter int TIMEOUT_CYCLES = 2700000,
    parameter int END_DELAY      = 32
) (
    input logic                 clk,
    input logic                 reset,
    image_frame_parser_if.slave bus
);
    localparam int DW = $clog2(END_DELAY);
    typedef enum logic [1:0] {HUNT, PAYLOAD, END_WAIT, ERROR_WAIT} state_t;
    state_t        state, state_nx;
    logic [1:0]    hdr_idx, hdr_idx_nx;
    logic [21:0]   timer, timer_nx;
    logic [DW-1:0] dly, dly_nx;
    logic [7:0]    data_out, data_out_nx;
    logic          data_valid, data_valid_nx;
    logic          image_start, image_start_nx;
    logic          image_end, image_end_nx;
    logic          frame_error, frame_error_nx;
    logic [13:0]   char_count, char_count_nx;
    logic [7:0]    hdr_byte;
    logic          is_b64;
    assign hdr_byte = hdr_idx == 2'd0 ? 8'h49 : hdr_idx == 2'd1 ? 8'h4D : hdr_idx == 2'd2 ? 8'h47 : 8'h3A;
    assign is_b64 = (bus.rx_byte >= 8'h41 && bus.rx_byte <= 8'h5A) ||
                    (bus.rx_byte >= 8'h61 && bus.rx_byte <= 8'h7A) ||
                    (bus.rx_byte >= 8'h30 && bus.rx_byte <= 8'h39) ||
                    bus.rx_byte == 8'h2B || bus.rx_byte == 8'h2F || bus.rx_byte == 8'h3D;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            hdr_idx     <= '0;
            timer       <= '0;
            dly         <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            image_start <= 1'b0;
            image_end   <= 1'b0;
            frame_error <= 1'b0;
            char_count  <= '0;
        end else begin
            state       <= state_nx;
            hdr_idx     <= hdr_idx_nx;
            timer       <= timer_nx;
            dly         <= dly_nx;
            data_out    <= data_out_nx;
            data_valid  <= data_valid_nx;
            image_start <= image_start_nx;
            image_end   <= image_end_nx;
            frame_error <= frame_error_nx;
            char_count  <= char_count_nx;
        end
    end
    always_comb begin
        state_nx       = state;
        hdr_idx_nx     = hdr_idx;
        timer_nx       = timer;
        dly_nx         = dly;
        data_out_nx    = data_out;
        data_valid_nx  = 1'b0;
        image_start_nx = 1'b0;
        image_end_nx   = 1'b0;
        frame_error_nx = frame_error;
        char_count_nx  = char_count;
        case (state)
            HUNT: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == hdr_byte && hdr_idx == 2'd3) begin
                        image_start_nx = 1'b1;
                        char_count_nx  = '0;
                        frame_error_nx = 1'b0;
                        hdr_idx_nx     = '0;
                        timer_nx       = '0;
                        state_nx       = PAYLOAD;
                    end else if (bus.rx_byte == hdr_byte) begin
                        hdr_idx_nx = hdr_idx + 2'd1;
                    end else begin
                        // a stray 'I' can itself start a fresh header
                        hdr_idx_nx = bus.rx_byte == 8'h49 ? 2'd1 : 2'd0;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    timer_nx = '0;
                    if (is_b64) begin
                        data_out_nx   = bus.rx_byte;
                        data_valid_nx = 1'b1;
                        char_count_nx = &char_count ? char_count : char_count + 14'd1;
                    end else if (bus.rx_byte == 8'h0A) begin
                        frame_error_nx = frame_error | (char_count != 14'(EXPECTED_CHARS));
                        dly_nx         = DW'(1);
                        state_nx       = END_WAIT;
                    end else if (bus.rx_byte != 8'h0D) begin
                        frame_error_nx = 1'b1;
                        dly_nx         = DW'(1);
                        state_nx       = ERROR_WAIT;
                    end
                end else if (timer == 22'(TIMEOUT_CYCLES - 1)) begin
                    frame_error_nx = 1'b1;
                    dly_nx         = DW'(1);
                    state_nx       = ERROR_WAIT;
                end else begin
                    timer_nx = timer + 22'd1;
                end
            end
            END_WAIT, ERROR_WAIT: begin
                // the cycle that entered the wait counts as the first of END_DELAY,
                // so image_end lands END_DELAY cycles after the terminating byte
                if (dly == DW'(END_DELAY - 1)) begin
                    image_end_nx = 1'b1;
                    hdr_idx_nx   = '0;
                    state_nx     = HUNT;
                end else begin
                    dly_nx = dly + DW'(1);
                end
            end
        endcase
    end
    assign bus.data_out    = data_out;
    assign bus.data_valid  = data_valid;
    assign bus.image_start = image_start;
    assign bus.image_end   = image_end;
    assign bus.frame_error = frame_error;
    assign bus.char_count  = char_count;
endmodule

// File: tb/tb_image_frame_parser.sv
// tb_image_frame_parser: directed frames against a frame-level model of the parser plus literal checks.
module tb_image_frame_parser;
    localparam int EXP = 10240;
    localparam int TMO = 500;
    localparam int DLY = 32;
    localparam int M_HUNT = 0, M_PAY = 1, M_WAIT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    image_frame_parser_if bus();
    image_frame_parser #(.EXPECTED_CHARS(EXP), .TIMEOUT_CYCLES(TMO), .END_DELAY(DLY)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int asserts = 0, fails = 0;
    int mode = M_HUNT, m_cnt = 0, last_e = 0, wait_end = 0;
    logic [31:0] win = '0;
    bit ev_start[int];
    bit ev_end[int];
    logic [7:0] ev_dv[int];
    int err_at[int];
    int cnt_at[int];
    int cur_err = 0, cur_cnt = 0;

    function automatic bit is_b64(input logic [7:0] b);
        return (b >= "A" && b <= "Z") || (b >= "a" && b <= "z") || (b >= "0" && b <= "9") ||
               b == "+" || b == "/" || b == "=";
    endfunction

    // Resolve frame events (timeouts, delayed ends) that happened at edges before e.
    function automatic void advance(input int e);
        if (mode == M_PAY && e > last_e + TMO) begin
            err_at[last_e + TMO] = 1;
            mode = M_WAIT;
            wait_end = last_e + TMO + DLY - 1;
        end
        if (mode == M_WAIT && e > wait_end) begin
            ev_end[wait_end] = 1'b1;
            mode = M_HUNT;
            win = '0;
        end
    endfunction

    function automatic void model_byte(input int e, input logic [7:0] b);
        advance(e);
        if (mode == M_HUNT) begin
            win = {win[23:0], b};
            if (win == 32'h494D473A) begin
                ev_start[e] = 1'b1;
                m_cnt = 0;
                err_at[e] = 0;
                cnt_at[e] = 0;
                mode = M_PAY;
                last_e = e;
            end
        end else if (mode == M_PAY) begin
            last_e = e;
            if (is_b64(b)) begin
                ev_dv[e] = b;
                m_cnt = m_cnt < 16383 ? m_cnt + 1 : 16383;
                cnt_at[e] = m_cnt;
            end else if (b != 8'h0D) begin
                if (b != 8'h0A || m_cnt != EXP) err_at[e] = 1;
                mode = M_WAIT;
                wait_end = e + DLY - 1;
            end
        end
    endfunction

    function automatic void model_reset(input int e);
        advance(e);
        mode = M_HUNT;
        win = '0;
        m_cnt = 0;
        err_at[e] = 0;
        cnt_at[e] = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            advance(cyc + 1);
            if (err_at.exists(cyc)) cur_err = err_at[cyc];
            if (cnt_at.exists(cyc)) cur_cnt = cnt_at[cyc];
            chk("image_start", 32'(bus.image_start), 32'(ev_start.exists(cyc)));
            chk("image_end", 32'(bus.image_end), 32'(ev_end.exists(cyc)));
            chk("data_valid", 32'(bus.data_valid), 32'(ev_dv.exists(cyc)));
            if (ev_dv.exists(cyc)) chk("data_out", 32'(bus.data_out), 32'(ev_dv[cyc]));
            chk("frame_error", 32'(bus.frame_error), 32'(cur_err));
            chk("char_count", 32'(bus.char_count), 32'(cur_cnt));
        end
    end

    int n_dv = 0, n_a = 0, n_end = 0, start_edge = -1, end_edge = -1;
    logic [7:0] dv_q[$];
    always @(negedge clk) begin
        if (bus.image_start) start_edge = cyc;
        if (bus.image_end) begin
            n_end++;
            end_edge = cyc;
        end
        if (bus.data_valid) begin
            n_dv++;
            if (bus.data_out == 8'h41) n_a++;
            dv_q.push_back(bus.data_out);
        end
    end

    int last_tx = 0;
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_byte = b;
        bus.rx_valid = 1'b1;
        last_tx = cyc + 1;
        model_byte(cyc + 1, b);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_marks();
        n_dv = 0;
        n_a = 0;
        n_end = 0;
        dv_q.delete();
    endtask

    initial begin
        #1_500_000;
        fails++;
        $display("FAIL watchdog: simulation still running at time limit, expected to finish");
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        int colon, term;
        bus.rx_byte = '0;
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({bus.data_out, bus.data_valid, bus.image_start, bus.image_end,
                                  bus.frame_error, bus.char_count}), 32'd0);
        reset = 1'b0;

        // full good frame
        clear_marks();
        send_str("IMG:");
        colon = last_tx;
        idle(2);
        chk("t1_start_latency", 32'(start_edge - colon + 1), 32'd1);
        for (int i = 0; i < EXP; i++) send("A");
        send(8'h0A);
        term = last_tx;
        idle(40);
        chk("t1_dv_pulses", 32'(n_dv), 32'd10240);
        chk("t1_dv_bytes_A", 32'(n_a), 32'd10240);
        chk("t1_end_latency", 32'(end_edge - term + 1), 32'd32);
        chk("t1_end_count", 32'(n_end), 32'd1);
        chk("t1_frame_error", 32'(bus.frame_error), 32'd0);
        chk("t1_char_count", 32'(bus.char_count), 32'd10240);

        // repeated 'I' before header, short frame
        clear_marks();
        send_str("IIMG:QUJD");
        send(8'h0A);
        idle(40);
        chk("t2_dv_pulses", 32'(dv_q.size()), 32'd4);
        chk("t2_byte0", 32'(dv_q[0]), 32'h51);
        chk("t2_byte1", 32'(dv_q[1]), 32'h55);
        chk("t2_byte2", 32'(dv_q[2]), 32'h4A);
        chk("t2_byte3", 32'(dv_q[3]), 32'h44);
        chk("t2_char_count", 32'(bus.char_count), 32'd4);
        chk("t2_frame_error", 32'(bus.frame_error), 32'd1);
        chk("t2_end_count", 32'(n_end), 32'd1);

        // illegal byte mid-payload
        clear_marks();
        send_str("IMG:AB");
        send("*");
        term = last_tx;
        send_str("CD");
        idle(40);
        chk("t3_dv_pulses", 32'(n_dv), 32'd2);
        chk("t3_frame_error", 32'(bus.frame_error), 32'd1);
        chk("t3_char_count", 32'(bus.char_count), 32'd2);
        chk("t3_end_latency", 32'(end_edge - term + 1), 32'd32);
        chk("t3_end_count", 32'(n_end), 32'd1);

        // idle timeout, then a fresh header clears the error
        clear_marks();
        send_str("IMG:AB");
        idle(TMO + DLY + 20);
        chk("t4_frame_error", 32'(bus.frame_error), 32'd1);
        chk("t4_end_count", 32'(n_end), 32'd1);
        send_str("IMG:");
        idle(2);
        chk("t4_restart_error", 32'(bus.frame_error), 32'd0);
        chk("t4_restart_count", 32'(bus.char_count), 32'd0);
        idle(TMO + DLY + 20);

        // reset mid-frame, then a CR LF terminated good frame
        clear_marks();
        send_str("IMG:ABC");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset(cyc + 1);
        idle(2);
        chk("t5_reset_outputs", 32'({bus.data_out, bus.data_valid, bus.image_start, bus.image_end,
                                     bus.frame_error, bus.char_count}), 32'd0);
        reset = 1'b0;
        idle(40);
        chk("t5_no_end_after_reset", 32'(n_end), 32'd0);
        clear_marks();
        send_str("IMG:");
        for (int i = 0; i < EXP; i++) send("A");
        send(8'h0D);
        send(8'h0A);
        term = last_tx;
        idle(40);
        chk("t5_dv_pulses", 32'(n_dv), 32'd10240);
        chk("t5_char_count", 32'(bus.char_count), 32'd10240);
        chk("t5_frame_error", 32'(bus.frame_error), 32'd0);
        chk("t5_end_latency", 32'(end_edge - term + 1), 32'd32);
        chk("t5_end_count", 32'(n_end), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
